// File: rtl/library_store_ctrl.sv
// Address and handshake controller for the coordinate library SRAM: records (x, y)
// streams into fixed-size slots, tracks each slot's committed length and replays slots.
module library_store_ctrl #(
    parameter int                COORD_W   = 5,
    parameter int                NUM_SLOTS = 26,
    parameter int                DEPTH_W   = 11,
    parameter int                SLOT_W    = 5,
    parameter int                ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] PARK_ADDR = 20'h06C00
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [COORD_W-1:0]   i_x,
    input  logic [COORD_W-1:0]   i_y,
    input  logic                 i_commit,
    input  logic                 i_abort,
    input  logic                 i_rd_start,
    input  logic [SLOT_W-1:0]    i_rd_slot,
    input  logic                 i_rd_ready,
    output logic                 o_we,
    output logic [2*COORD_W-1:0] o_wdata,
    output logic [ADDR_W-1:0]    o_addr,
    output logic                 o_rd_valid,
    output logic                 o_rd_last,
    output logic [SLOT_W-1:0]    o_slot,
    output logic                 o_busy,
    output logic                 o_full,
    output logic                 o_err
);

    localparam int CNT_W = DEPTH_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(2**DEPTH_W);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W:0]   SLOTS_C   = (SLOT_W+1)'(NUM_SLOTS);

    typedef enum logic [1:0] {
        IDLE,
        REC,
        PLAY
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]   len_q [NUM_SLOTS];
    logic [CNT_W-1:0]   len_d [NUM_SLOTS];

    logic               rd_slot_ok;
    logic [CNT_W-1:0]   req_len;
    logic [CNT_W-1:0]   cur_len;
    logic               is_full;
    logic               wr_ok;
    logic               play_last;
    logic [CNT_W-1:0]   rec_total;

    // Out-of-range playback requests must never index the length table.
    assign rd_slot_ok = ({1'b0, i_rd_slot} < SLOTS_C);
    assign req_len    = rd_slot_ok ? len_q[i_rd_slot] : '0;
    assign cur_len    = len_q[rd_slot_q];
    assign is_full    = (count_q == DEPTH_C);
    assign wr_ok      = (state_q == REC) && i_valid && !is_full && !i_abort;
    assign play_last  = ({1'b0, idx_q} == (cur_len - CNT_W'(1)));
    assign rec_total  = count_q + CNT_W'(wr_ok);

    assign o_busy  = (state_q != IDLE);
    assign o_slot  = slot_q;
    assign o_wdata = {i_x, i_y};

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        rd_slot_d  = rd_slot_q;
        count_d    = count_q;
        idx_d      = idx_q;
        len_d      = len_q;
        o_we       = 1'b0;
        o_err      = 1'b0;
        o_rd_valid = 1'b0;
        o_rd_last  = 1'b0;
        o_full     = 1'b0;
        o_addr     = PARK_ADDR;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = REC;
                    count_d = '0;
                end else if (i_rd_start) begin
                    if (!rd_slot_ok || (req_len == '0)) begin
                        o_err = 1'b1;
                    end else begin
                        rd_slot_d = i_rd_slot;
                        idx_d     = '0;
                        state_d   = PLAY;
                    end
                end
            end

            REC: begin
                o_addr = ADDR_W'({slot_q, count_q[DEPTH_W-1:0]});
                o_full = is_full;
                o_we   = wr_ok;
                if (wr_ok) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (i_valid && is_full && !i_abort) begin
                    o_err = 1'b1;
                end
                // A commit that would store nothing leaves the slot free, like an abort.
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_commit) begin
                    state_d = IDLE;
                    if (rec_total != '0) begin
                        len_d[slot_q] = rec_total;
                        slot_d        = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
                    end
                end
            end

            PLAY: begin
                o_rd_valid = 1'b1;
                o_rd_last  = play_last;
                o_addr     = ADDR_W'({rd_slot_q, idx_q});
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_rd_ready) begin
                    if (play_last) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + DEPTH_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            rd_slot_q <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            rd_slot_q <= rd_slot_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: doc/library_store_ctrl.md
Name: library_store_ctrl

Overview:
- Address/handshake controller for the coordinate library memory.
- Records streams of (x, y) pairs into one of NUM_SLOTS fixed-size slots and tracks each slot's committed length. Replays any committed slot as an address stream for readback.
- Sits between the coordinate front end and the shared SRAM. Emits write enable, write data and address. Parks the address at PARK_ADDR when idle.

Parameters:
- COORD_W, 5, width of each coordinate.
- NUM_SLOTS, 26, number of library slots (>=2).
- DEPTH_W, 11, log2 of entries per slot; DEPTH = 2**DEPTH_W.
- SLOT_W, 5, slot index width; 2**SLOT_W >= NUM_SLOTS.
- ADDR_W, 20, memory address width; must be >= SLOT_W+DEPTH_W.
- PARK_ADDR, 20'h06C00, address driven whenever no access is in progress.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  begin recording into the current write slot
- i_valid  in  1  i_x/i_y hold a pair to store (REC only)
- i_x  in  COORD_W  x coordinate
- i_y  in  COORD_W  y coordinate
- i_commit  in  1  close the record and keep it
- i_abort  in  1  discard the record, or stop playback
- i_rd_start  in  1  begin playback of i_rd_slot
- i_rd_slot  in  SLOT_W  slot to replay
- i_rd_ready  in  1  consumer accepts the current playback address
- o_we  out  1  memory write strobe
- o_wdata  out  2*COORD_W  {i_x, i_y}
- o_addr  out  ADDR_W  {zero pad, slot, index}, or PARK_ADDR
- o_rd_valid  out  1  o_addr is a valid playback address
- o_rd_last  out  1  current playback address is the final entry of the slot
- o_slot  out  SLOT_W  current write slot
- o_busy  out  1  state != IDLE
- o_full  out  1  REC and the slot holds DEPTH entries
- o_err  out  1  one-cycle pulse on a rejected request or dropped data

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; slot, count and playback index clear to 0.
  - All NUM_SLOTS length entries clear to 0.
  - Outputs at reset: o_we=0, o_rd_valid=0, o_rd_last=0, o_busy=0, o_full=0, o_err=0, o_slot=0, o_addr=PARK_ADDR, o_wdata={i_x,i_y}.
  - A reset mid-record or mid-playback loses the open record. Previously committed lengths are also cleared.
- States: IDLE, REC, PLAY. Outputs are combinational from state, registers and inputs. There is no added latency.
- IDLE:
  - o_addr=PARK_ADDR.
  - i_start goes to REC and clears count to 0.
  - Otherwise, i_rd_start is checked; i_start has priority.
    - If i_rd_slot >= NUM_SLOTS, or len[i_rd_slot]==0, pulse o_err and stay in IDLE.
    - Otherwise latch the slot, clear the index to 0 and go to PLAY.
  - i_valid, i_commit, i_abort and i_rd_ready are ignored.
- REC:
  - o_addr={slot, count[DEPTH_W-1:0]}.
  - If i_valid, count<DEPTH and not i_abort: o_we=1 in the same cycle and count increments.
  - If i_valid and count==DEPTH: no write, o_err pulses, and the pair is dropped.
  - o_full = (count==DEPTH).
  - i_abort: go to IDLE; slot and len are unchanged; a concurrent i_valid is not written. i_abort wins over i_commit.
  - i_commit with no abort:
    - len[slot] <= count plus 1 if the same-cycle write was accepted.
    - If that total is nonzero, slot advances, wrapping from NUM_SLOTS-1 to 0.
    - If the total is 0, the commit behaves as an abort: no advance, len unchanged.
    - Next state is IDLE.
  - i_start and i_rd_start are ignored while in REC.
- PLAY:
  - o_rd_valid=1, o_addr={rd_slot, idx}, o_rd_last = (idx==len[rd_slot]-1).
  - i_rd_ready advances idx. A handshake with o_rd_last set returns to IDLE.
  - i_abort goes to IDLE immediately, with no handshake in that cycle.
  - i_start and i_rd_start are ignored.
- Widths:
  - count is DEPTH_W+1 bits. len entries are DEPTH_W+1 bits; DEPTH is a legal length.
  - The zero pad is ADDR_W-SLOT_W-DEPTH_W bits.
- Replaying the current write slot is legal; it reads the previously committed content of that slot.

Test Plan:
- Record and commit: reset, i_start, 3 valid pairs (1,2),(3,4),(5,6), then i_commit -> o_we on 3 cycles at o_addr 0x00000, 0x00001, 0x00002; o_wdata=0x022 on the first write; len[0]=3; o_slot=1; o_addr=0x06C00 after.
- Commit with valid in the same cycle: i_start, then one cycle with i_valid=1 and i_commit=1 -> one write at 0x00800 (slot 1); len[1]=1; o_slot=2.
- Abort and empty commit: i_abort with i_valid high -> no o_we, o_slot unchanged. i_start then i_commit with zero writes -> o_slot unchanged, len unchanged.
- Overflow (DEPTH_W=2): 5 valid pairs -> 4 writes at indices 0..3; o_full=1 after the 4th; o_err pulses on the 5th; commit gives len=4.
- Playback: replay slot 0 (len 3) with i_rd_ready toggling 1,0,1,1 -> addresses 0,1,1,2; o_rd_last only at index 2; IDLE after the final handshake. Replay of an empty slot or slot 26 -> o_err pulse and state stays IDLE.
- Wrap and mid-operation reset: 26 nonempty commits -> o_slot wraps 25->0. Assert i_rst_n low during REC -> o_we=0, o_addr=0x06C00, o_slot=0 immediately, and all lens read as empty.
